pwm_led: RTL and testbench
==========================

PWM_LED -- requirements
Module: pwm_led

Interface
REQ-001 SHALL have parameter NCH, default 3, number of PWM channels (1..6).
REQ-002 SHALL have parameter W, default 8, duty/counter width in bits (1..8).
REQ-003 SHALL have parameter PRESC_W, default 8, prescaler register width (1..8).
REQ-004 SHALL have ports: clk in 1, system clock; rst in 1, reset.
REQ-005 SHALL have ports: rd_en in 1, read strobe; addr in 5, byte address; rd_data out 8, read data; rd_valid out 1, read data valid.
REQ-006 SHALL have ports: wr_en in 1, write strobe; wr_data in 8, write data.
REQ-007 SHALL have port led out NCH, PWM outputs, bit k = channel k.
REQ-008 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-009 SHALL decode: 4*k = DUTY[k] (k<NCH), 0x18 = PRESC, 0x1C = CTRL (bit0 EN, bit1 INV, bit2 FADE); other addresses ignore writes and read 0.
REQ-010 SHALL assert rd_valid for exactly one cycle, the cycle after rd_en, with rd_data valid in that cycle; rd_data holds otherwise.
REQ-011 SHALL zero-extend registers narrower than 8 bits on read; SHALL truncate wr_data to register width on write.
REQ-012 SHALL return the pre-write value on a read and write to the same address in the same cycle.
REQ-013 SHALL generate tick every PRESC+1 clk cycles while EN=1; PRESC=0 gives tick every cycle.
REQ-014 SHALL advance the W-bit period counter by 1 per tick, wrapping 2^W-1 -> 0.
REQ-015 SHALL drive raw output of channel k high iff counter < ACTIVE[k]; ACTIVE=0 always low; ACTIVE=2^W-1 high 2^W-1 of 2^W ticks.
REQ-016 SHALL drive led[k] = raw[k] XOR INV, registered, one clk after counter update.
REQ-017 SHALL load DUTY[k] (shadow) into ACTIVE[k] only on the tick at which the counter wraps to 0; no mid-period duty change.
REQ-018 SHALL, when EN=0, hold prescaler and counter at 0, ACTIVE unchanged, led = {NCH{INV}}.
REQ-019 SHALL, on EN 0->1, start a fresh period at counter 0 and load ACTIVE from DUTY on the first tick.

Reset
REQ-020 SHALL on rst clear DUTY, ACTIVE, PRESC, CTRL, counter, prescaler, rd_data, rd_valid, led to 0.
REQ-021 SHALL let rst override any simultaneous rd_en/wr_en; reset mid-period SHALL abort the period with no glitch beyond led=0.

Configuration
REQ-022 SHALL compile fade support only when macro PWM_LED_FADE_EN is defined.
REQ-023 With PWM_LED_FADE_EN and FADE=1: at each wrap ACTIVE[k] SHALL step by 1 toward DUTY[k] (stop when equal) instead of REQ-017 load.
REQ-024 Without PWM_LED_FADE_EN: CTRL bit2 SHALL read 0, writes ignored; REQ-017 always applies.

Structure
REQ-025 SHALL place register address constants and CTRL bit indices in package pwm_led_pkg.
REQ-026 SHALL instantiate one sub-module pwm_led_chan per channel (shadow/active duty, fade step, compare, polarity register); bus decode, prescaler and counter in pwm_led.

Verification
REQ-027 W=8, PRESC=0, EN=1, DUTY[0]=64 -> led[0] high exactly 64 of every 256 clk, period start aligned to wrap.
REQ-028 DUTY[1]=200 written at counter 100 -> current period unchanged, next period 200 high clocks.
REQ-029 DUTY=0 and DUTY=255 -> always low; high 255/256; INV=1 inverts both; EN=0 -> led=INV constant.
REQ-030 PRESC=3 -> counter advances every 4 clk; period = 1024 clk; read 0x18 returns 3 with rd_valid one cycle after rd_en; read 0x14 (NCH=3) returns 0.
REQ-031 PWM_LED_FADE_EN, FADE=1, ACTIVE=10, DUTY=13 -> ACTIVE 11,12,13 on three successive wraps then stays; without macro, CTRL read returns bit2=0.
REQ-032 rst asserted mid-period with wr_en -> next cycle all registers 0, led=0, write discarded.

Source files
------------

// File: rtl/pwm_led_pkg.sv
// ============================================================================
//  Module      : pwm_led_pkg
//  Description : Register map and CTRL bit positions for the pwm_led block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_led_pkg;

    localparam logic [4:0] c_ADDR_PRESC = 5'h18;
    localparam logic [4:0] c_ADDR_CTRL  = 5'h1C;

    localparam int c_CTRL_EN   = 0;
    localparam int c_CTRL_INV  = 1;
    localparam int c_CTRL_FADE = 2;
    localparam int c_CTRL_W    = 3;

    // Channel k's duty register lives at byte address 4*k
    function automatic logic [4:0] duty_addr(input int k);
        return 5'(4 * k);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_led_chan.sv
// ============================================================================
//  Module      : pwm_led_chan
//  Description : One PWM channel: shadow/active duty, optional fade stepping
//                (PWM_LED_FADE_EN), compare and registered polarity output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_led_chan
    import pwm_led_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         duty_we,
    input  logic [W-1:0] duty_wdata,
    input  logic         load,
    input  logic         fade,
    input  logic         out_en,
    input  logic         inv,
    input  logic [W-1:0] cnt,
    output logic [W-1:0] duty,
    output logic         led
);

    logic [W-1:0] r_duty;
    logic [W-1:0] r_active;
    logic         r_led;
    logic         w_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= '0;
        end else if (duty_we) begin
            r_duty <= duty_wdata;
        end
    end

    // ACTIVE only changes at a period boundary so a period is never torn
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
        end else if (load) begin
`ifdef PWM_LED_FADE_EN
            if (fade) begin
                if (r_active < r_duty) begin
                    r_active <= r_active + W'(1);
                end else if (r_active > r_duty) begin
                    r_active <= r_active - W'(1);
                end
            end else begin
                r_active <= r_duty;
            end
`else
            r_active <= r_duty;
`endif
        end
    end

`ifndef PWM_LED_FADE_EN
    logic w_unused_fade;
    assign w_unused_fade = fade;
`endif

    assign w_raw = out_en && (cnt < r_active);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_raw ^ inv;
        end
    end

    assign duty = r_duty;
    assign led  = r_led;

endmodule

`default_nettype wire

// File: rtl/pwm_led.sv
// ============================================================================
//  Module      : pwm_led
//  Description : Multi-channel LED PWM with byte register bus, prescaler and
//                shared period counter. Fade support under PWM_LED_FADE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_led
    import pwm_led_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int W       = 8,
    parameter int PRESC_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rd_en,
    input  logic [4:0]     addr,
    output logic [7:0]     rd_data,
    output logic           rd_valid,
    input  logic           wr_en,
    input  logic [7:0]     wr_data,
    output logic [NCH-1:0] led
);

    logic [PRESC_W-1:0]        r_presc;
    logic [PRESC_W-1:0]        r_psc_cnt;
    logic [c_CTRL_W-1:0]       r_ctrl;
    logic [W-1:0]              r_cnt;
    logic                      r_fresh;
    logic [7:0]                r_rd_data;
    logic                      r_rd_valid;

    logic                      w_en;
    logic                      w_tick;
    logic                      w_load;
    logic                      w_out_en;
    logic                      w_fade;
    logic [NCH-1:0]            w_duty_we;
    logic [NCH-1:0][W-1:0]     w_duty;
    logic [7:0]                w_rd_mux;

    assign w_en     = r_ctrl[c_CTRL_EN];
    assign w_tick   = w_en && (r_psc_cnt == r_presc);
    // r_fresh marks the idle slot after enable; its tick opens period 0
    assign w_load   = w_tick && (r_fresh || (r_cnt == '1));
    assign w_out_en = w_en && !r_fresh;

`ifdef PWM_LED_FADE_EN
    assign w_fade = r_ctrl[c_CTRL_FADE];
`else
    assign w_fade = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_ctrl  <= '0;
        end else if (wr_en) begin
            if (addr == c_ADDR_PRESC) begin
                r_presc <= wr_data[PRESC_W-1:0];
            end
            if (addr == c_ADDR_CTRL) begin
                r_ctrl[c_CTRL_EN]   <= wr_data[c_CTRL_EN];
                r_ctrl[c_CTRL_INV]  <= wr_data[c_CTRL_INV];
`ifdef PWM_LED_FADE_EN
                r_ctrl[c_CTRL_FADE] <= wr_data[c_CTRL_FADE];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !w_en) begin
            r_psc_cnt <= '0;
            r_cnt     <= '0;
            r_fresh   <= 1'b1;
        end else if (w_tick) begin
            r_psc_cnt <= '0;
            r_cnt     <= r_fresh ? '0 : r_cnt + W'(1);
            r_fresh   <= 1'b0;
        end else begin
            r_psc_cnt <= r_psc_cnt + PRESC_W'(1);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NCH; k++) begin
            if (addr == duty_addr(k)) begin
                w_rd_mux[W-1:0] = w_duty[k];
            end
        end
        if (addr == c_ADDR_PRESC) begin
            w_rd_mux[PRESC_W-1:0] = r_presc;
        end
        if (addr == c_ADDR_CTRL) begin
            w_rd_mux[c_CTRL_W-1:0] = r_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_chan
            assign w_duty_we[k] = wr_en && (addr == duty_addr(k));

            pwm_led_chan #(
                .W(W)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .duty_we    (w_duty_we[k]),
                .duty_wdata (wr_data[W-1:0]),
                .load       (w_load),
                .fade       (w_fade),
                .out_en     (w_out_en),
                .inv        (r_ctrl[c_CTRL_INV]),
                .cnt        (r_cnt),
                .duty       (w_duty[k]),
                .led        (led[k])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pwm_led.sv
// ============================================================================
//  Module      : tb_pwm_led
//  Description : Self-checking bench for pwm_led (NCH=3, W=8, PRESC_W=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_led;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic [4:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    wire  [7:0] rd_data;
    wire        rd_valid;
    wire  [2:0] led;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [2:0] trace[$];

    pwm_led #(.NCH(3), .W(8), .PRESC_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .addr     (addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_data  (wr_data)
        ,.led     (led)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Expected pushed at the strobe, observed output captured one cycle later
    task automatic rd(input logic [4:0] a, input logic [7:0] e);
        @(negedge clk);
        rd_en = 1'b1; addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
        got_q.push_back({rd_valid, rd_data});
    endtask

    task automatic wait_edge(input int ch, input logic level, output logic ok);
        logic prev;
        ok   = 1'b0;
        prev = led[ch];
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (led[ch] === level && prev !== level) begin
                ok = 1'b1;
                break;
            end
            prev = led[ch];
        end
    endtask

    task automatic capture(input int n);
        trace.delete();
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            trace.push_back(led);
        end
    endtask

    function automatic int count_hi(input int ch, input int len);
        int c = 0;
        for (int j = 0; j < len; j++) c += int'(trace[j][ch]);
        return c;
    endfunction

    function automatic int shape_err(input int ch, input int len, input int hi_len, input logic inv);
        int c = 0;
        for (int j = 0; j < len; j++) begin
            if (trace[j][ch] !== ((j < hi_len) ^ inv)) c++;
        end
        return c;
    endfunction

    task automatic test_reset;
        logic [7:0] e;
        logic [8:0] g;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b1; addr = 5'h00; wr_data = 8'hFF;
        repeat (3) @(negedge clk);
        total++; if (led !== 3'b000) begin bad++; $display("FAIL reset_led got=%b exp=000", led); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        rst = 1'b0; wr_en = 1'b0;
        rd(5'h00, 8'h00); rd(5'h04, 8'h00); rd(5'h08, 8'h00);
        rd(5'h18, 8'h00); rd(5'h1C, 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== {1'b1, e}) begin bad++; $display("FAIL reset_rd got=%h exp=%h", g, {1'b1, e}); end
        end
    endtask

    task automatic test_regs;
        logic [7:0] e;
        logic [8:0] g;
        wr(5'h00, 8'hA5); wr(5'h04, 8'h3C); wr(5'h08, 8'h01);
        wr(5'h18, 8'h07); wr(5'h1C, 8'hFE); wr(5'h14, 8'hFF);
        rd(5'h00, 8'hA5); rd(5'h04, 8'h3C); rd(5'h08, 8'h01); rd(5'h18, 8'h07);
`ifdef PWM_LED_FADE_EN
        rd(5'h1C, 8'h06);
`else
        rd(5'h1C, 8'h02);
`endif
        rd(5'h14, 8'h00); rd(5'h0C, 8'h00); rd(5'h1F, 8'h00);
        // read and write to the same address in one cycle returns the old value
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b1; addr = 5'h00; wr_data = 8'h11;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        got_q.push_back({rd_valid, rd_data});
        rd(5'h00, 8'h11);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== {1'b1, e}) begin bad++; $display("FAIL regs_rd got=%h exp=%h", g, {1'b1, e}); end
        end
        wr(5'h1C, 8'h00);
    endtask

    task automatic test_pwm_basic;
        logic ok;
        int   n;
        wr(5'h00, 8'd64); wr(5'h04, 8'd0); wr(5'h08, 8'd255);
        wr(5'h18, 8'd0);  wr(5'h1C, 8'h01);
        wait_edge(0, 1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_rise got=timeout exp=edge"); end
        capture(257);
        n = shape_err(0, 256, 64, 1'b0);
        total++; if (n != 0) begin bad++; $display("FAIL basic_duty64_shape got=%0d exp=0", n); end
        n = count_hi(1, 256);
        total++; if (n != 0) begin bad++; $display("FAIL basic_duty0 got=%0d exp=0", n); end
        n = count_hi(2, 256);
        total++; if (n != 255) begin bad++; $display("FAIL basic_duty255 got=%0d exp=255", n); end
        total++; if (trace[256][0] !== 1'b1) begin bad++; $display("FAIL basic_wrap got=%b exp=1", trace[256][0]); end
    endtask

    task automatic test_shadow;
        int n;
        repeat (100) @(negedge clk);
        wr(5'h04, 8'd200);
        capture(154);
        n = count_hi(1, 154);
        total++; if (n != 0) begin bad++; $display("FAIL shadow_current got=%0d exp=0", n); end
        @(negedge clk);
        capture(256);
        n = shape_err(1, 256, 200, 1'b0);
        total++; if (n != 0) begin bad++; $display("FAIL shadow_next_shape got=%0d exp=0", n); end
        n = shape_err(0, 256, 64, 1'b0);
        total++; if (n != 0) begin bad++; $display("FAIL shadow_ch0_shape got=%0d exp=0", n); end
    endtask

    task automatic test_inv_en;
        logic ok;
        int   n;
        wr(5'h1C, 8'h03);
        wait_edge(0, 1'b1, ok);
        wait_edge(0, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL inv_edge got=timeout exp=edge"); end
        capture(256);
        n = shape_err(0, 256, 64, 1'b1);
        total++; if (n != 0) begin bad++; $display("FAIL inv_ch0_shape got=%0d exp=0", n); end
        n = count_hi(1, 256);
        total++; if (n != 56) begin bad++; $display("FAIL inv_ch1 got=%0d exp=56", n); end
        n = count_hi(2, 256);
        total++; if (n != 1) begin bad++; $display("FAIL inv_ch2 got=%0d exp=1", n); end
        wr(5'h1C, 8'h02);
        repeat (3) @(negedge clk);
        capture(20);
        n = 0;
        for (int j = 0; j < 20; j++) if (trace[j] !== 3'b111) n++;
        total++; if (n != 0) begin bad++; $display("FAIL en0_inv1 got=%0d bad_samples exp=0", n); end
        wr(5'h1C, 8'h00);
        repeat (3) @(negedge clk);
        capture(20);
        n = 0;
        for (int j = 0; j < 20; j++) if (trace[j] !== 3'b000) n++;
        total++; if (n != 0) begin bad++; $display("FAIL en0_inv0 got=%0d bad_samples exp=0", n); end
    endtask

    task automatic test_presc;
        logic       ok;
        int         n;
        logic [7:0] e;
        logic [8:0] g;
        wr(5'h18, 8'd3);
        @(negedge clk);
        rd_en = 1'b1; addr = 5'h18;
        exp_q.push_back(8'd3);
        @(negedge clk);
        rd_en = 1'b0;
        got_q.push_back({rd_valid, rd_data});
        @(negedge clk);
        total++; if (rd_valid !== 1'b0 || rd_data !== 8'd3) begin
            bad++; $display("FAIL presc_rd_hold got=%b/%h exp=0/03", rd_valid, rd_data);
        end
        rd(5'h14, 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== {1'b1, e}) begin bad++; $display("FAIL presc_rd got=%h exp=%h", g, {1'b1, e}); end
        end
        wr(5'h1C, 8'h01);
        wait_edge(0, 1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL presc_rise got=timeout exp=edge"); end
        capture(1025);
        n = shape_err(0, 1024, 256, 1'b0);
        total++; if (n != 0) begin bad++; $display("FAIL presc_ch0_shape got=%0d exp=0", n); end
        n = count_hi(1, 1024);
        total++; if (n != 800) begin bad++; $display("FAIL presc_ch1 got=%0d exp=800", n); end
        n = count_hi(2, 1024);
        total++; if (n != 1020) begin bad++; $display("FAIL presc_ch2 got=%0d exp=1020", n); end
        total++; if (trace[1024][0] !== 1'b1) begin bad++; $display("FAIL presc_period got=%b exp=1", trace[1024][0]); end
    endtask

    task automatic test_fade;
        logic       ok;
        int         n;
        int         exp_hi[4];
        logic [7:0] e;
        logic [8:0] g;
`ifdef PWM_LED_FADE_EN
        exp_hi = '{11, 12, 13, 13};
`else
        exp_hi = '{13, 13, 13, 13};
`endif
        wr(5'h1C, 8'h00); wr(5'h18, 8'd0); wr(5'h00, 8'd10); wr(5'h1C, 8'h01);
        wait_edge(0, 1'b1, ok);
        capture(256);
        n = count_hi(0, 256);
        total++; if (n != 10) begin bad++; $display("FAIL fade_start got=%0d exp=10", n); end
        repeat (50) @(negedge clk);
        wr(5'h00, 8'd13); wr(5'h1C, 8'h05);
        wait_edge(0, 1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL fade_rise got=timeout exp=edge"); end
        for (int p = 0; p < 4; p++) begin
            capture(256);
            n = count_hi(0, 256);
            total++; if (n != exp_hi[p]) begin bad++; $display("FAIL fade_period%0d got=%0d exp=%0d", p, n, exp_hi[p]); end
            @(negedge clk);
        end
`ifdef PWM_LED_FADE_EN
        rd(5'h1C, 8'h05);
`else
        rd(5'h1C, 8'h01);
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== {1'b1, e}) begin bad++; $display("FAIL fade_ctrl_rd got=%h exp=%h", g, {1'b1, e}); end
        end
    endtask

    task automatic test_reset_mid;
        int         n;
        logic [7:0] e;
        logic [8:0] g;
        rd(5'h08, 8'd255);
        repeat (30) @(negedge clk);
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = 5'h00; wr_data = 8'h55;
        @(negedge clk);
        total++; if (led !== 3'b000) begin bad++; $display("FAIL rstmid_led got=%b exp=000", led); end
        total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            bad++; $display("FAIL rstmid_rd got=%b/%h exp=0/00", rd_valid, rd_data);
        end
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        capture(10);
        n = 0;
        for (int j = 0; j < 10; j++) if (trace[j] !== 3'b000) n++;
        total++; if (n != 0) begin bad++; $display("FAIL rstmid_led_after got=%0d bad_samples exp=0", n); end
        rd(5'h00, 8'h00); rd(5'h08, 8'h00); rd(5'h18, 8'h00); rd(5'h1C, 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== {1'b1, e}) begin bad++; $display("FAIL rstmid_rd_regs got=%h exp=%h", g, {1'b1, e}); end
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_pwm_basic();
        test_shadow();
        test_inv_en();
        test_presc();
        test_fade();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
